// File: rtl/return_address_stack.sv
// Return address stack for the fetch-stage predictor: circular storage of link
// addresses, pushed on resolved calls and popped on resolved returns in execute.
package ras_pkg;
  typedef enum logic [1:0] {
    CFLOW_NONE   = 2'd0,
    CFLOW_BRANCH = 2'd1,
    CFLOW_JAL    = 2'd2,
    CFLOW_JALR   = 2'd3
  } cflow_mode_t;

  typedef enum logic [1:0] {
    CFHINT_NONE = 2'd0,
    CFHINT_CALL = 2'd1,
    CFHINT_RET  = 2'd2
  } cflow_hint_t;
endpackage

module return_address_stack
  import ras_pkg::*;
#(
  parameter  int RAS_DEPTH = 8,
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update_en,
  input  cflow_mode_t       cflow_mode,
  input  cflow_hint_t       cflow_hint,
  input  logic [31:0]       pc_e,
  input  logic              ras_clear,
  output logic              ras_empty,
  output logic              ras_full,
  output logic [PTR_W:0]    ras_count,
  output logic [31:0]       ras_pop_addr
);

  localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [31:0]      mem [RAS_DEPTH];
  logic [PTR_W-1:0] tos_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W-1:0] tos_nxt_s;
  logic [PTR_W:0]   count_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             mem_we_s;

  // Decode call/return from the resolved control-flow class and hint.
  always_comb begin
    push_s = update_en
           && ((cflow_mode == CFLOW_JAL) || (cflow_mode == CFLOW_JALR))
           && (cflow_hint == CFHINT_CALL);
    pop_s  = update_en && (cflow_mode == CFLOW_JALR) && (cflow_hint == CFHINT_RET);
    mem_we_s = push_s && !ras_clear;
  end

  // Next-state pointer/occupancy with clear > push > pop priority.
  always_comb begin
    tos_nxt_s   = tos_r;
    count_nxt_s = count_r;
    if (ras_clear) begin
      count_nxt_s = '0;
    end else if (push_s) begin
      // A push while full recycles the oldest slot, so occupancy saturates.
      tos_nxt_s = tos_r + PTR_ONE;
      if (count_r == COUNT_MAX) begin
        count_nxt_s = count_r;
      end else begin
        count_nxt_s = count_r + COUNT_ONE;
      end
    end else if (pop_s) begin
      if (count_r != '0) begin
        tos_nxt_s   = tos_r - PTR_ONE;
        count_nxt_s = count_r - COUNT_ONE;
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      tos_nxt_s   = tos_r;
      count_nxt_s = count_r;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tos_r   <= '0;
      count_r <= '0;
    end else begin
      tos_r   <= tos_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are never reset, empty masking hides stale data.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem[tos_r + PTR_ONE] <= pc_e + 32'd4;
    end
  end

  // Status and top-of-stack outputs derived from state.
  always_comb begin
    ras_empty = (count_r == '0);
    ras_full  = (count_r == COUNT_MAX);
    ras_count = count_r;
    if (ras_empty) begin
      ras_pop_addr = 32'h0;
    end else begin
      ras_pop_addr = mem[tos_r];
    end
  end

endmodule
